// File: rtl/ariane_pkg.sv
// Shared types and helpers for the integer mult/div functional unit.
// Holds the divide-op encoding and the divider-frontend sequencing states.
package ariane_pkg;

  localparam int TRANS_ID_BITS = 3;

  typedef enum logic [2:0] {
    DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE, LAUNCH, WAIT, RESP
  } div_fe_state_e;

  // Divider opcode: 0 udiv, 1 div, 2 urem, 3 rem (bit 0 marks a signed op).
  function automatic logic [1:0] div_opcode(div_op_e op);
    case (op)
      DIVU, DIVUW: return 2'd0;
      DIV,  DIVW:  return 2'd1;
      REMU, REMUW: return 2'd2;
      default:     return 2'd3;
    endcase
  endfunction

  function automatic logic is_word_op(div_op_e op);
    return op inside {DIVW, DIVUW, REMW, REMUW};
  endfunction

endpackage

// File: rtl/div_frontend_if.sv
// Issue, divider and writeback signals of the divider frontend.
// slave is the frontend's view; master is the surrounding pipeline and divider.
interface div_frontend_if #(
  parameter int WIDTH      = 64,
  parameter int TRANS_ID_W = ariane_pkg::TRANS_ID_BITS
);
  logic                      valid_i;
  logic                      ready_o;
  ariane_pkg::div_op_e       op_i;
  logic [WIDTH-1:0]          operand_a_i;
  logic [WIDTH-1:0]          operand_b_i;
  logic [TRANS_ID_W-1:0]     trans_id_i;

  logic [TRANS_ID_W-1:0]     div_id_o;
  logic [WIDTH-1:0]          div_op_a_o;
  logic [WIDTH-1:0]          div_op_b_o;
  logic [1:0]                div_opcode_o;
  logic                      div_in_vld_o;
  logic                      div_in_rdy_i;
  logic                      div_out_vld_i;
  logic                      div_out_rdy_o;
  logic [TRANS_ID_W-1:0]     div_id_i;
  logic [WIDTH-1:0]          div_res_i;

  logic                      valid_o;
  logic                      ready_i;
  logic [WIDTH-1:0]          result_o;
  logic [TRANS_ID_W-1:0]     trans_id_o;

  modport slave (
    input  valid_i, op_i, operand_a_i, operand_b_i, trans_id_i,
    input  div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i, ready_i,
    output ready_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
    output div_in_vld_o, div_out_rdy_o, valid_o, result_o, trans_id_o
  );

  modport master (
    output valid_i, op_i, operand_a_i, operand_b_i, trans_id_i,
    output div_in_rdy_i, div_out_vld_i, div_id_i, div_res_i, ready_i,
    input  ready_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
    input  div_in_vld_o, div_out_rdy_o, valid_o, result_o, trans_id_o
  );
endinterface

// File: rtl/div_frontend.sv
// Issue adapter and result stage around the 64-bit serial divider.
// One op in flight: prepare operands, launch with a one-cycle gap, hold result.
module div_frontend
  import ariane_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int TRANS_ID_W = TRANS_ID_BITS
) (
  input logic           clk_i,
  input logic           rst_ni,
  input logic           flush_i,
  div_frontend_if.slave bus
);

  localparam int HALF = WIDTH / 2;

  div_fe_state_e         state_q, state_d;
  logic [WIDTH-1:0]      op_a_q, op_b_q, result_q;
  logic [WIDTH-1:0]      op_a_d, op_b_d, result_d;
  logic [1:0]            opcode_q, opcode_d;
  logic [TRANS_ID_W-1:0] id_q, res_id_q;
  logic                  word_q;
  logic                  accept, capture;

  assign opcode_d = div_opcode(bus.op_i);
  assign accept   = bus.valid_i & bus.ready_o;
  assign capture  = (state_q == WAIT) & bus.div_out_vld_i & ~flush_i;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    op_a_d = bus.operand_a_i;
    op_b_d = bus.operand_b_i;
    if (is_word_op(bus.op_i)) begin
      if (opcode_d[0]) begin
        op_a_d = {{HALF{bus.operand_a_i[HALF-1]}}, bus.operand_a_i[HALF-1:0]};
        op_b_d = {{HALF{bus.operand_b_i[HALF-1]}}, bus.operand_b_i[HALF-1:0]};
      end else begin
        op_a_d = {{HALF{1'b0}}, bus.operand_a_i[HALF-1:0]};
        op_b_d = {{HALF{1'b0}}, bus.operand_b_i[HALF-1:0]};
      end
    end
  end

  // W results are always sign-extended from bit 31, unsigned W ops included.
  assign result_d = word_q ? {{HALF{bus.div_res_i[HALF-1]}}, bus.div_res_i[HALF-1:0]}
                           : bus.div_res_i;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)             state_d = LAUNCH;
      LAUNCH:  if (bus.div_in_rdy_i)   state_d = WAIT;
      WAIT:    if (bus.div_out_vld_i)  state_d = RESP;
      RESP:    if (bus.ready_i)        state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    bus.ready_o       = (state_q == IDLE)   & bus.div_in_rdy_i & ~flush_i & rst_ni;
    bus.div_in_vld_o  = (state_q == LAUNCH) & bus.div_in_rdy_i & ~flush_i;
    bus.div_out_rdy_o = (state_q == WAIT);
    bus.valid_o       = (state_q == RESP)   & ~flush_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      id_q     <= '0;
      word_q   <= 1'b0;
      result_q <= '0;
      res_id_q <= '0;
    end else begin
      if (accept) begin
        op_a_q   <= op_a_d;
        op_b_q   <= op_b_d;
        opcode_q <= opcode_d;
        id_q     <= bus.trans_id_i;
        word_q   <= is_word_op(bus.op_i);
      end
      if (flush_i) begin
        result_q <= '0;
        res_id_q <= '0;
      end else if (capture) begin
        result_q <= result_d;
        res_id_q <= bus.div_id_i;
      end
    end
  end

  assign bus.div_op_a_o   = op_a_q;
  assign bus.div_op_b_o   = op_b_q;
  assign bus.div_opcode_o = opcode_q;
  assign bus.div_id_o     = id_q;
  assign bus.result_o     = result_q;
  assign bus.trans_id_o   = res_id_q;

endmodule
